// File: rtl/lfsr_delay_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_delay_pkg
//  Shared types and widths for the LFSR-driven random delay timer.
//  Contents:
//   delay_state_t  FSM state encoding (IDLE, COUNT, DONE, MEASURE)
//   DELAY_W        width of the random value, captured delay and tick count
//   REACT_W        width of the reaction-time counter
// -----------------------------------------------------------------------------
package lfsr_delay_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      DONE    = 2'd2,
      MEASURE = 2'd3
   } delay_state_t;

   localparam int DELAY_W = 8;
   localparam int REACT_W = 16;

endpackage : lfsr_delay_pkg

// File: rtl/lfsr_delay_timer.sv
// -----------------------------------------------------------------------------
// lfsr_delay_timer
//  Turns the current LFSR value into a random delay. A trigger in IDLE
//  captures K = max(rnd, MIN_DELAY); the block then counts K time-base ticks
//  and pulses time_out for one cycle. lfsr_en pulses once per accepted
//  trigger so the LFSR advances once per delay. All outputs are registered.
//
//  Optional feature (macro LFSR_DELAY_REACTION_EN): after time_out the FSM
//  enters MEASURE and counts clk cycles (saturating) until react, then reports
//  the count on react_time with a one-cycle react_valid pulse.
//
//  Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous reset, active low
//   tick         in   1        one-cycle time-base strobe
//   trigger      in   1        start request, honoured only in IDLE
//   abort        in   1        synchronous cancel, wins over everything but rst
//   rnd          in   WIDTH    LFSR value, sampled on an accepted trigger
//   lfsr_en      out  1        one-cycle pulse in the cycle after capture
//   busy         out  1        high in every state except IDLE
//   count        out  WIDTH    remaining ticks, 0 when idle
//   time_out     out  1        one-cycle pulse when the delay expires
//   react        in   1        (macro only) player response strobe
//   react_time   out  REACT_W  (macro only) cycles from time_out to react
//   react_valid  out  1        (macro only) pulse when react_time updates
// -----------------------------------------------------------------------------
module lfsr_delay_timer
   import lfsr_delay_pkg::*;
#(
   parameter int WIDTH     = DELAY_W,
   parameter int MIN_DELAY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               trigger,
   input  logic               abort,
   input  logic [WIDTH-1:0]   rnd,
   output logic               lfsr_en,
   output logic               busy,
   output logic [WIDTH-1:0]   count,
`ifdef LFSR_DELAY_REACTION_EN
   input  logic               react,
   output logic [REACT_W-1:0] react_time,
   output logic               react_valid,
`endif
   output logic               time_out
);

   localparam logic [WIDTH-1:0] MIN_LOAD = WIDTH'(MIN_DELAY);

   delay_state_t     r_state;
   delay_state_t     w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_lfsr_en;
   logic             r_busy;
   logic             r_time_out;
   logic             w_accept;
   logic             w_expire;

`ifdef LFSR_DELAY_REACTION_EN
   logic [REACT_W-1:0] r_react_cnt;
   logic [REACT_W-1:0] w_react_cnt_nxt;
   logic [REACT_W-1:0] r_react_time;
   logic               r_react_valid;
   logic               w_react_hit;
`endif

   // A trigger is taken only in IDLE, and abort always wins over it.
   assign w_accept = (r_state == IDLE) && trigger && !abort;

   // "<= 1" rather than "== 1" so a zero load (MIN_DELAY = 0) still finishes
   // after one tick instead of wrapping.
   assign w_expire = (r_state == COUNT) && tick && (r_count <= WIDTH'(1));

`ifdef LFSR_DELAY_REACTION_EN
   assign w_react_hit = (r_state == MEASURE) && react && !abort;
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (trigger)  w_state_nxt = COUNT;
            COUNT:   if (w_expire) w_state_nxt = DONE;
`ifdef LFSR_DELAY_REACTION_EN
            DONE:    w_state_nxt = MEASURE;
            MEASURE: if (react)    w_state_nxt = IDLE;
`else
            DONE:    w_state_nxt = IDLE;
            MEASURE: w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output / datapath next values
   // ---------------------------------------------------------------------------
   always_comb begin
      w_count_nxt = r_count;
      if (abort) begin
         w_count_nxt = '0;
      end else if (w_accept) begin
         w_count_nxt = (rnd < MIN_LOAD) ? MIN_LOAD : rnd;
      end else if ((r_state == COUNT) && tick && (r_count != '0)) begin
         // A tick coinciding with the trigger never reaches here: the FSM is
         // still in IDLE during that cycle.
         w_count_nxt = r_count - WIDTH'(1);
      end
`ifdef LFSR_DELAY_REACTION_EN
      w_react_cnt_nxt = r_react_cnt;
      if (r_state == DONE) begin
         // Cleared during the time_out cycle so MEASURE starts at 0.
         w_react_cnt_nxt = '0;
      end else if ((r_state == MEASURE) && (r_react_cnt != '1)) begin
         w_react_cnt_nxt = r_react_cnt + REACT_W'(1);
      end
`endif
   end

   // Output registers: pulses and busy are computed from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count    <= '0;
         r_lfsr_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_time_out <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_lfsr_en  <= w_accept;
         r_busy     <= (w_state_nxt != IDLE);
         r_time_out <= (w_state_nxt == DONE);
      end
   end

`ifdef LFSR_DELAY_REACTION_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_react_cnt   <= '0;
         r_react_time  <= '0;
         r_react_valid <= 1'b0;
      end else begin
         r_react_cnt   <= w_react_cnt_nxt;
         r_react_valid <= w_react_hit;
         if (w_react_hit) r_react_time <= r_react_cnt;
      end
   end

   assign react_time  = r_react_time;
   assign react_valid = r_react_valid;
`endif

   assign lfsr_en  = r_lfsr_en;
   assign busy     = r_busy;
   assign count    = r_count;
   assign time_out = r_time_out;

endmodule : lfsr_delay_timer

// File: tb/tb_lfsr_delay_timer.sv
// -----------------------------------------------------------------------------
// tb_lfsr_delay_timer
//  Directed bench for lfsr_delay_timer. The stimulus thread pushes the cycle
//  at which each lfsr_en / time_out (and react_valid) pulse must appear into
//  queues; a monitor on the falling edge pops and compares whenever the DUT
//  raises one of those pulses. Steady-state values (count, busy) are checked
//  inline. Covers LFSR_DELAY_REACTION_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_lfsr_delay_timer;
   import lfsr_delay_pkg::*;

   logic                clk     = 1'b0;
   logic                rst     = 1'b1;
   logic                tick    = 1'b0;
   logic                trigger = 1'b0;
   logic                abort   = 1'b0;
   logic [DELAY_W-1:0]  rnd     = '0;
   logic                lfsr_en;
   logic                busy;
   logic [DELAY_W-1:0]  count;
   logic                time_out;
`ifdef LFSR_DELAY_REACTION_EN
   logic                react = 1'b0;
   logic [REACT_W-1:0]  react_time;
   logic                react_valid;
`endif

   typedef struct {
      int                 cyc;
      logic [REACT_W-1:0] val;
   } rv_t;

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   int  q_en[$];
   int  q_to[$];
   rv_t q_rv[$];

   lfsr_delay_timer #(.WIDTH(DELAY_W), .MIN_DELAY(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .trigger    (trigger),
      .abort      (abort),
      .rnd        (rnd),
      .lfsr_en    (lfsr_en),
      .busy       (busy),
      .count      (count),
`ifdef LFSR_DELAY_REACTION_EN
      .react      (react),
      .react_time (react_time),
      .react_valid(react_valid),
`endif
      .time_out   (time_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
      end
   endtask

   // Drive inputs for exactly one clock, starting at the current falling edge.
   task automatic drive(input logic trg, input logic tk, input logic ab);
      trigger = trg; tick = tk; abort = ab;
      @(negedge clk);
      trigger = 1'b0; tick = 1'b0; abort = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on the time_out cycle: return the DUT to IDLE.
   task automatic leave_done();
      idle(1);
`ifdef LFSR_DELAY_REACTION_EN
      check("busy_in_measure", busy, 1);
      drive(0, 0, 1);
`endif
      check("busy_after_done", busy, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (lfsr_en === 1'b1) begin
         if (q_en.size() == 0) check("lfsr_en_unexpected", 1, 0);
         else                  check("lfsr_en_cycle", cyc, q_en.pop_front());
      end
      if (time_out === 1'b1) begin
         if (q_to.size() == 0) check("time_out_unexpected", 1, 0);
         else begin
            check("time_out_cycle", cyc, q_to.pop_front());
            check("time_out_count", count, 0);
         end
      end
`ifdef LFSR_DELAY_REACTION_EN
      if (react_valid === 1'b1) begin
         if (q_rv.size() == 0) check("react_valid_unexpected", 1, 0);
         else begin
            rv_t e;
            e = q_rv.pop_front();
            check("react_valid_cycle", cyc, e.cyc);
            check("react_time_value", react_time, e.val);
         end
      end
`endif
   end

   initial begin
      // Power-on reset
      #1 rst = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_lfsr_en", lfsr_en, 0);
      check("rst_time_out", time_out, 0);
`ifdef LFSR_DELAY_REACTION_EN
      check("rst_react_time", react_time, 0);
      check("rst_react_valid", react_valid, 0);
`endif
      idle(2);
      rst = 1'b1;
      idle(1);

      // 1: async reset mid-count (count=5, lfsr_en high at that moment)
      rnd = 8'd5;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      check("t1_count_loaded", count, 5);
      #2 rst = 1'b0;
      #1;
      check("t1_rst_count", count, 0);
      check("t1_rst_busy", busy, 0);
      check("t1_rst_lfsr_en", lfsr_en, 0);
      check("t1_rst_time_out", time_out, 0);
      idle(2);
      rst = 1'b1;
      idle(1);
      check("t1_idle_busy", busy, 0);
      for (int i = 0; i < 6; i++) drive(0, 1, 0);
      check("t1_idle_count", count, 0);

      // 2: rnd=3, tick every 4 clocks
      rnd = 8'h03;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      check("t2_count_loaded", count, 3);
      check("t2_busy", busy, 1);
      for (int k = 1; k <= 3; k++) begin
         idle(3);
         if (k == 3) q_to.push_back(cyc + 1);
         drive(0, 1, 0);
         check($sformatf("t2_count_after_tick%0d", k), count, 3 - k);
      end
      check("t2_busy_in_done", busy, 1);
      leave_done();

      // 3: rnd=0 loads MIN_DELAY=1
      rnd = 8'h00;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      check("t3_count_min", count, 1);
      idle(2);
      q_to.push_back(cyc + 1);
      drive(0, 1, 0);
      leave_done();

      // 4: trigger+tick coincident, triggers during COUNT ignored
      rnd = 8'h02;
      q_en.push_back(cyc + 1);
      drive(1, 1, 0);
      check("t4_tick_with_trigger_ignored", count, 2);
      rnd = 8'h09;
      drive(1, 0, 0);
      check("t4_retrigger_ignored", count, 2);
      drive(0, 1, 0);
      check("t4_count_1", count, 1);
      idle(1);
      q_to.push_back(cyc + 1);
      drive(1, 1, 0);
      check("t4_count_0", count, 0);
      leave_done();

      // 4b: trigger held across the end of a delay re-triggers once idle
      rnd = 8'h01;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      trigger = 1'b1;
      tick    = 1'b1;
      rnd     = 8'h04;
      q_to.push_back(cyc + 1);
      @(negedge clk);                  // DONE cycle
      tick = 1'b0;
`ifdef LFSR_DELAY_REACTION_EN
      @(negedge clk);                  // first MEASURE cycle, counter=0
      check("t4b_busy_measure", busy, 1);
      react = 1'b1;
      q_rv.push_back('{cyc: cyc + 1, val: 16'd0});
      q_en.push_back(cyc + 2);
      @(negedge clk);
      react = 1'b0;
      check("t4b_busy_idle", busy, 0);
`else
      q_en.push_back(cyc + 2);
      @(negedge clk);
      check("t4b_busy_idle", busy, 0);
`endif
      @(negedge clk);
      trigger = 1'b0;
      check("t4b_retrigger_count", count, 4);
      check("t4b_retrigger_busy", busy, 1);
      drive(0, 0, 1);
      check("t4b_abort_busy", busy, 0);

      // 5: abort at count=2, then abort+trigger in IDLE
      rnd = 8'h04;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      drive(0, 1, 0);
      drive(0, 1, 0);
      check("t5_count_2", count, 2);
      drive(0, 0, 1);
      check("t5_abort_count", count, 0);
      check("t5_abort_busy", busy, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0);
      rnd = 8'h07;
      drive(1, 0, 1);
      check("t5_abort_trigger_busy", busy, 0);
      check("t5_abort_trigger_count", count, 0);
      idle(1);
      check("t5_still_idle", busy, 0);

`ifdef LFSR_DELAY_REACTION_EN
      // 6: reaction time of 37 cycles
      rnd = 8'h01;
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      q_to.push_back(cyc + 1);
      drive(0, 1, 0);                  // time_out cycle
      idle(38);                        // counter now reads 37
      react = 1'b1;
      q_rv.push_back('{cyc: cyc + 1, val: 16'd37});
      @(negedge clk);
      react = 1'b0;
      check("t6_busy_after_react", busy, 0);
      idle(1);
      check("t6_react_time_hold", react_time, 37);

      // 6b: saturation
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      q_to.push_back(cyc + 1);
      drive(0, 1, 0);
      idle(70000);
      react = 1'b1;
      q_rv.push_back('{cyc: cyc + 1, val: 16'hFFFF});
      @(negedge clk);
      react = 1'b0;

      // 6c: abort in MEASURE gives no react_valid
      q_en.push_back(cyc + 1);
      drive(1, 0, 0);
      q_to.push_back(cyc + 1);
      drive(0, 1, 0);
      idle(5);
      drive(0, 0, 1);
      check("t6c_abort_busy", busy, 0);
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
      idle(1);
      check("t6c_react_time_hold", react_time, 16'hFFFF);
`endif

      // Every expected pulse must have been seen
      idle(4);
      check("q_lfsr_en_empty", q_en.size(), 0);
      check("q_time_out_empty", q_to.size(), 0);
      check("q_react_empty", q_rv.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_lfsr_delay_timer
